ram_param: RTL and testbench



---
 rtl/ram_pkg.sv | 25 ++
 rtl/ram_clear_seq.sv | 44 ++++
 rtl/ram_param.sv | 110 +++++++++++
 tb/tb_ram_param.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ram_pkg
//  Description : Shared state encoding, default geometry and parity helper
//                for the parametrised word-addressed RAM.
//  Revision    : 1.0  initial release
// ============================================================================
package ram_pkg;

    localparam int unsigned c_width_def  = 16;
    localparam int unsigned c_addr_w_def = 3;

    localparam int unsigned c_state_w  = 1;
    localparam logic [c_state_w-1:0] c_st_clear = 1'b0;
    localparam logic [c_state_w-1:0] c_st_idle  = 1'b1;

    // Words are zero-extended to this width before parity; zeros do not alter it.
    localparam int unsigned c_par_max_w = 256;

    function automatic logic f_even_parity(input logic [c_par_max_w-1:0] d);
        return ^d;
    endfunction

endpackage : ram_pkg
`default_nettype wire

// File: rtl/ram_clear_seq.sv
`default_nettype none
// ============================================================================
//  Module      : ram_clear_seq
//  Description : Walks a pointer over every word after reset, producing the
//                clear write strobe/address and the busy flag.
//  Revision    : 1.0  initial release
// ============================================================================
module ram_clear_seq
    import ram_pkg::*;
#(
    parameter int ADDR_W = c_addr_w_def
) (
    input  logic              clk,
    input  logic              rst,
    output logic              o_busy,
    output logic              o_clr_we,
    output logic [ADDR_W-1:0] o_clr_addr
);

    logic [c_state_w-1:0] r_state;
    logic [ADDR_W-1:0]    r_ptr;
    logic                 r_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_clear;
            r_ptr   <= '0;
            r_busy  <= 1'b1;
        end else if (r_state == c_st_clear) begin
            // Pointer wraps back to zero as the last word is cleared.
            r_ptr <= r_ptr + 1'b1;
            if (&r_ptr) begin
                r_state <= c_st_idle;
                r_busy  <= 1'b0;
            end
        end
    end

    assign o_busy     = r_busy;
    assign o_clr_we   = (r_state == c_st_clear);
    assign o_clr_addr = r_ptr;

endmodule : ram_clear_seq
`default_nettype wire

// File: rtl/ram_param.sv
`default_nettype none
// ============================================================================
//  Module      : ram_param
//  Description : WIDTH x 2**ADDR_W RAM with self-clearing reset, registered
//                read-first access and valid strobe. Define RAM_PARITY_EN to
//                store an even-parity bit per word and expose par_err.
//  Revision    : 1.0  initial release
// ============================================================================
module ram_param
    import ram_pkg::*;
#(
    parameter int WIDTH  = c_width_def,
    parameter int ADDR_W = c_addr_w_def
) (
    input  logic              clk,
    input  logic              re,
    input  logic              e,
    input  logic [WIDTH-1:0]  DIn,
    input  logic [ADDR_W-1:0] addr,
    input  logic              w,
    input  logic              r,
    output logic [WIDTH-1:0]  DOut,
    output logic              valid,
`ifdef RAM_PARITY_EN
    output logic              par_err,
`endif
    output logic              busy
);

    localparam int c_depth = 2 ** ADDR_W;
`ifdef RAM_PARITY_EN
    localparam int c_word_w = WIDTH + 1;
`else
    localparam int c_word_w = WIDTH;
`endif

    logic [c_word_w-1:0] r_mem [c_depth];
    logic [WIDTH-1:0]    r_dout;
    logic                r_valid;

    logic                w_busy;
    logic                w_clr_we;
    logic [ADDR_W-1:0]   w_clr_addr;
    logic                w_user_we;
    logic                w_user_rd;
    logic [c_word_w-1:0] w_wdata;
    logic [c_word_w-1:0] w_rd_word;

    ram_clear_seq #(
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk        (clk),
        .rst        (re),
        .o_busy     (w_busy),
        .o_clr_we   (w_clr_we),
        .o_clr_addr (w_clr_addr)
    );

    assign w_user_we = !re && !w_busy && e && w;
    assign w_user_rd = !re && !w_busy && e && r;
    assign w_rd_word = r_mem[addr];

`ifdef RAM_PARITY_EN
    assign w_wdata = {f_even_parity(c_par_max_w'(DIn)), DIn};
`else
    assign w_wdata = DIn;
`endif

    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[w_clr_addr] <= '0;
        end else if (w_user_we) begin
            r_mem[addr] <= w_wdata;
        end
    end

    // Read samples the array before this edge's write lands: read-first on collision.
    always_ff @(posedge clk) begin
        if (re || w_busy) begin
            r_dout  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_user_rd;
            if (w_user_rd) begin
                r_dout <= w_rd_word[WIDTH-1:0];
            end
        end
    end

`ifdef RAM_PARITY_EN
    logic r_par_err;

    always_ff @(posedge clk) begin
        if (re || w_busy) begin
            r_par_err <= 1'b0;
        end else begin
            r_par_err <= w_user_rd &&
                         (f_even_parity(c_par_max_w'(w_rd_word[WIDTH-1:0])) != w_rd_word[WIDTH]);
        end
    end

    assign par_err = r_par_err;
`endif

    assign DOut  = r_dout;
    assign valid = r_valid;
    assign busy  = w_busy;

endmodule : ram_param
`default_nettype wire

// File: tb/tb_ram_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_param
//  Description : Randomised self-checking bench for ram_param against an
//                array-based reference model (optionally RAM_PARITY_EN).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ram_param;

    localparam int WIDTH = 16;
    localparam int DEPTH = 8;
    localparam int DEPTH6 = 64;

    logic        clk;
    logic        re, e, w, r;
    logic [15:0] din;
    logic [2:0]  addr;
    logic [15:0] dout;
    logic        valid, busy;

    logic        re6, e6, w6, r6;
    logic [15:0] din6;
    logic [5:0]  addr6;
    logic [15:0] dout6;
    logic        valid6, busy6;

`ifdef RAM_PARITY_EN
    logic        par_err, par_err6;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [15:0] mem_m [DEPTH];
    logic [15:0] exp_dout;
    logic        exp_valid;
    int          clr_left;

    ram_param #(.WIDTH(WIDTH), .ADDR_W(3)) u_dut (
        .clk (clk), .re (re), .e (e), .DIn (din), .addr (addr), .w (w), .r (r),
        .DOut (dout), .valid (valid),
`ifdef RAM_PARITY_EN
        .par_err (par_err),
`endif
        .busy (busy)
    );

    ram_param #(.WIDTH(WIDTH), .ADDR_W(6)) u_dut6 (
        .clk (clk), .re (re6), .e (e6), .DIn (din6), .addr (addr6), .w (w6), .r (r6),
        .DOut (dout6), .valid (valid6),
`ifdef RAM_PARITY_EN
        .par_err (par_err6),
`endif
        .busy (busy6)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle of stimulus on the 8-word RAM, then compare with the model.
    task automatic step(input bit rs, input bit en, input bit wr, input bit rd,
                        input int a, input logic [15:0] d);
        re = rs; e = en; w = wr; r = rd; addr = 3'(a); din = d;
        tick();
        exp_valid = 1'b0;
        if (rs) begin
            clr_left = DEPTH;
            exp_dout = '0;
            for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
        end else if (clr_left > 0) begin
            clr_left--;
        end else begin
            if (en && rd) begin
                exp_dout  = mem_m[a];
                exp_valid = 1'b1;
            end
            if (en && wr) mem_m[a] = d;
        end
        check("busy", 32'(busy), 32'(clr_left > 0));
        check("valid", 32'(valid), 32'(exp_valid));
        check("dout", 32'(dout), 32'(exp_dout));
`ifdef RAM_PARITY_EN
        check("par_err", 32'(par_err), 32'd0);
`endif
    endtask

    initial begin
        int n;
        re = 1'b1; e = 0; w = 0; r = 0; din = '0; addr = '0;
        re6 = 1'b1; e6 = 0; w6 = 0; r6 = 0; din6 = '0; addr6 = '0;
        exp_dout = '0; exp_valid = 1'b0; clr_left = DEPTH;

        // Reset, then attempt a write to addr 2 throughout the clear.
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) step(0, 1, 1, 0, 2, 16'd55);

        // All words read as zero, valid on every read.
        for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 1, i, 0);

        // Write i+1 to each address, read back.
        for (int i = 0; i < DEPTH; i++) step(0, 1, 1, 0, i, 16'(i + 1));
        for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 1, i, 0);

        // Collision: read-first on addr 3.
        step(0, 1, 1, 1, 3, 16'd99);
        check("collision_old", 32'(dout), 32'd4);
        step(0, 1, 0, 1, 3, 0);
        check("collision_new", 32'(dout), 32'd99);

        // Enable low blocks the write.
        step(0, 0, 1, 0, 5, 16'd77);
        step(0, 1, 0, 1, 5, 0);
        check("e0_write_blocked", 32'(dout), 32'd6);

        // Randomised traffic with occasional re-clears.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 79) == 0), ($urandom_range(0, 3) != 0),
                 1'($urandom), 1'($urandom), int'($urandom_range(0, DEPTH - 1)),
                 16'($urandom));
        end

        // 64-word instance: reset again 30 cycles into the first clear.
        re6 = 1'b1;
        tick();
        re6 = 1'b0;
        for (int i = 0; i < 30; i++) tick();
        check("busy6_mid", 32'(busy6), 32'd1);
        re6 = 1'b1;
        tick();
        re6 = 1'b0;
        n = 0;
        while (busy6 === 1'b1 && n < 200) begin
            n++;
            tick();
        end
        check("busy6_len", 32'(n), 32'(DEPTH6));
        e6 = 1'b1; r6 = 1'b1; addr6 = 6'd63;
        tick();
        r6 = 1'b0; e6 = 1'b0;
        check("dout6_63", 32'(dout6), 32'd0);
        check("valid6_63", 32'(valid6), 32'd1);

`ifdef RAM_PARITY_EN
        step(0, 1, 1, 0, 0, 16'h0007);
        step(0, 1, 0, 1, 0, 0);
        u_dut.r_mem[0][1] = ~u_dut.r_mem[0][1];
        re = 0; e = 1; w = 0; r = 1; addr = '0;
        tick();
        r = 0;
        check("par_err_flip", 32'(par_err), 32'd1);
        check("par_valid_flip", 32'(valid), 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_ram_param
`default_nettype wire
